// File: rtl/seq_gen_serial_if.sv
// Pattern-request and serial-output bundle for seq_gen_serial.
// master = pattern requester / stream consumer, slave = the transmitter.
interface seq_gen_serial_if #(
    parameter int unsigned WIDTH = 8
) ();
    localparam int unsigned LW = $clog2(WIDTH) + 1;

    logic             start_in;
    logic [WIDTH-1:0] pattern_in;
    logic [LW-1:0]    len_in;
    logic [3:0]       repeat_in;
    logic             data_out;
    logic             valid_out;
    logic             busy_out;
    logic             done_out;

    modport master (
        output start_in, pattern_in, len_in, repeat_in,
        input  data_out, valid_out, busy_out, done_out
    );

    modport slave (
        input  start_in, pattern_in, len_in, repeat_in,
        output data_out, valid_out, busy_out, done_out
    );
endinterface

// File: rtl/seq_gen_serial.sv
// Serial pattern transmitter: sends the low len bits of a latched word MSB-first,
// repeat+1 times with GAP_CYCLES idle cycles between repetitions.
module seq_gen_serial #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned GAP_CYCLES = 2,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic               clock_in,
    input  logic               rst_n_in,
    seq_gen_serial_if.slave    bus
);
    localparam int unsigned IW       = $clog2(WIDTH);
    localparam int unsigned LW       = IW + 1;
    localparam int unsigned GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q,   pat_d;
    logic [LW-1:0]    len_q,   len_d;
    logic [IW-1:0]    idx_q,   idx_d;
    logic [3:0]       rep_q,   rep_d;
    logic [GW-1:0]    gap_q,   gap_d;
    logic             data_q,  data_d;
    logic             valid_q, valid_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic [LW-1:0]    len_c;
    logic [IW-1:0]    first_idx_c;
    logic [IW-1:0]    reload_idx_c;

    // Out-of-range lengths (0 or above WIDTH) mean a full-width pattern
    always_comb begin
        len_c = bus.len_in;
        if (bus.len_in == LW'(0) || bus.len_in > LW'(WIDTH)) begin
            len_c = LW'(WIDTH);
        end
        first_idx_c  = IW'(len_c - LW'(1));
        reload_idx_c = IW'(len_q - LW'(1));
    end

    // Outputs are computed for the next cycle so they leave straight from flops
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        data_d  = IDLE_LEVEL;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start_in) begin
                    pat_d   = bus.pattern_in;
                    len_d   = len_c;
                    rep_d   = bus.repeat_in;
                    idx_d   = first_idx_c;
                    state_d = S_SHIFT;
                    data_d  = bus.pattern_in[first_idx_c];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_SHIFT: begin
                busy_d = 1'b1;
                if (idx_q != IW'(0)) begin
                    idx_d   = idx_q - IW'(1);
                    data_d  = pat_q[idx_d];
                    valid_d = 1'b1;
                end else if (rep_q == 4'd0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    rep_d = rep_q - 4'd1;
                    idx_d = reload_idx_c;
                    if (GAP_CYCLES == 0) begin
                        data_d  = pat_q[reload_idx_c];
                        valid_d = 1'b1;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = GW'(GAP_LAST);
                    end
                end
            end
            S_GAP: begin
                busy_d = 1'b1;
                if (gap_q == GW'(0)) begin
                    state_d = S_SHIFT;
                    data_d  = pat_q[idx_q];
                    valid_d = 1'b1;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            data_q  <= IDLE_LEVEL;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.busy_out  = busy_q;
    assign bus.done_out  = done_q;
endmodule
